dut_keypad_scan: RTL



---
 rtl/dut_keypad_scan.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/dut_keypad_scan.sv
// Matrix keypad scanner: one-hot column drive, 2-flop row synchroniser, press/release debounce,
// multi-key rejection and valid/ready key delivery. Define KEYPAD_REPEAT_EN for auto-repeat while held.
module dut_keypad_scan #(
    parameter int KEY_ROW      = 4,
    parameter int KEY_COL      = 4,
    parameter int SCAN_CYC     = 4,
    parameter int DEBOUNCE_CYC = 16,
    parameter int REPEAT_CYC   = 256
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [KEY_ROW-1:0]                 row_sense,
    output logic [KEY_COL-1:0]                 col_drv,
    output logic [$clog2(KEY_ROW*KEY_COL)-1:0] key,
    output logic                               valid,
    input  logic                               ready,
    output logic                               multi
);
    localparam int KEY_W   = $clog2(KEY_ROW*KEY_COL);
    localparam int COL_W   = (KEY_COL > 1) ? $clog2(KEY_COL) : 1;
    localparam int ROW_W   = (KEY_ROW > 1) ? $clog2(KEY_ROW) : 1;
    localparam int MAX_A   = (SCAN_CYC > DEBOUNCE_CYC) ? SCAN_CYC : DEBOUNCE_CYC;
    localparam int CNT_MAX = (MAX_A > REPEAT_CYC) ? MAX_A : REPEAT_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_WAIT_ACK = 2'd2,
        ST_HOLD     = 2'd3
    } state_t;

    function automatic logic multi_hot(input logic [KEY_ROW-1:0] v);
        return (v & (v - KEY_ROW'(1))) != '0;
    endfunction

    function automatic logic [ROW_W-1:0] row_index(input logic [KEY_ROW-1:0] v);
        logic [ROW_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < KEY_ROW; i++) begin
            idx = v[i] ? ROW_W'(i) : idx;
        end
        return idx;
    endfunction

    function automatic logic [COL_W-1:0] next_col(input logic [COL_W-1:0] c);
        return (c == COL_W'(KEY_COL - 1)) ? '0 : c + COL_W'(1);
    endfunction

    function automatic logic [KEY_W-1:0] key_code(input logic [ROW_W-1:0] r, input logic [COL_W-1:0] c);
        return KEY_W'(KEY_COL) * KEY_W'(r) + KEY_W'(c);
    endfunction

    logic [KEY_ROW-1:0] sync1_r, rs_r;
    state_t             state_r, state_s;
    logic [COL_W-1:0]   col_idx_r, col_idx_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic [KEY_ROW-1:0] pat_r, pat_s;
    logic [KEY_W-1:0]   key_r, key_s;
    logic               valid_r, valid_s;
    logic               multi_r, multi_s;
    logic [KEY_COL-1:0] col_drv_r;
`ifdef KEYPAD_REPEAT_EN
    logic [CNT_W-1:0]   rep_cnt_r, rep_cnt_s;
    logic               rep_arm_r, rep_arm_s;
`endif

    // two-flop synchroniser for the asynchronous row lines
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= '0;
            rs_r    <= '0;
        end else begin
            sync1_r <= row_sense;
            rs_r    <= sync1_r;
        end
    end

    // scan / debounce / handshake / release next-state and output logic
    always_comb begin
        state_s   = state_r;
        col_idx_s = col_idx_r;
        cnt_s     = cnt_r;
        pat_s     = pat_r;
        key_s     = key_r;
        valid_s   = valid_r;
        multi_s   = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        rep_cnt_s = rep_cnt_r;
        rep_arm_s = rep_arm_r;
`endif
        case (state_r)
            ST_SCAN: begin
                if (cnt_r == CNT_W'(SCAN_CYC - 1)) begin
                    cnt_s = '0;
                    if (rs_r == '0) begin
                        col_idx_s = next_col(col_idx_r);
                    end else if (multi_hot(rs_r)) begin
                        multi_s   = 1'b1;
                        col_idx_s = next_col(col_idx_r);
                    end else begin
                        pat_s   = rs_r;
                        state_s = ST_DEBOUNCE;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_DEBOUNCE: begin
                if (rs_r != pat_r) begin
                    state_s   = ST_SCAN;
                    col_idx_s = next_col(col_idx_r);
                    cnt_s     = '0;
                end else if (cnt_r == CNT_W'(DEBOUNCE_CYC - 1)) begin
                    key_s   = key_code(row_index(pat_r), col_idx_r);
                    valid_s = 1'b1;
                    state_s = ST_WAIT_ACK;
                    cnt_s   = '0;
`ifdef KEYPAD_REPEAT_EN
                    rep_arm_s = 1'b1;
                    rep_cnt_s = '0;
`endif
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_WAIT_ACK: begin
                if (valid_r && ready) begin
                    valid_s = 1'b0;
                    state_s = ST_HOLD;
                    cnt_s   = '0;
                end else begin
                    valid_s = valid_r;
                end
            end
            ST_HOLD: begin
                if (rs_r != '0) begin
                    cnt_s = '0;
                end else if (cnt_r == CNT_W'(DEBOUNCE_CYC - 1)) begin
                    state_s   = ST_SCAN;
                    col_idx_s = next_col(col_idx_r);
                    cnt_s     = '0;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
`ifdef KEYPAD_REPEAT_EN
                // an unchanged pattern keeps the repeat timer running; any change disarms it for this press
                if (rep_arm_r && (rs_r == pat_r)) begin
                    if (rep_cnt_r == CNT_W'(REPEAT_CYC - 1)) begin
                        rep_cnt_s = '0;
                        valid_s   = 1'b1;
                        state_s   = ST_WAIT_ACK;
                    end else begin
                        rep_cnt_s = rep_cnt_r + CNT_W'(1);
                    end
                end else begin
                    rep_arm_s = 1'b0;
                    rep_cnt_s = '0;
                end
`endif
            end
            default: begin
                state_s   = ST_SCAN;
                col_idx_s = '0;
                cnt_s     = '0;
                valid_s   = 1'b0;
            end
        endcase
    end

    // state, datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_SCAN;
            col_idx_r <= '0;
            cnt_r     <= '0;
            pat_r     <= '0;
            key_r     <= '0;
            valid_r   <= 1'b0;
            multi_r   <= 1'b0;
            col_drv_r <= '0;
        end else begin
            state_r   <= state_s;
            col_idx_r <= col_idx_s;
            cnt_r     <= cnt_s;
            pat_r     <= pat_s;
            key_r     <= key_s;
            valid_r   <= valid_s;
            multi_r   <= multi_s;
            col_drv_r <= KEY_COL'(1) << col_idx_s;
        end
    end

`ifdef KEYPAD_REPEAT_EN
    // auto-repeat timer and arm flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt_r <= '0;
            rep_arm_r <= 1'b0;
        end else begin
            rep_cnt_r <= rep_cnt_s;
            rep_arm_r <= rep_arm_s;
        end
    end
`endif

    assign col_drv = col_drv_r;
    assign key     = key_r;
    assign valid   = valid_r;
    assign multi   = multi_r;

endmodule
